// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that serialises JK set/clear/toggle
// operations from NREQ requesters onto one shared WIDTH-bit JK bank.
//
// Handshake: a lane raises req and holds it until it sees its ack pulse.
// The lane's J/K vectors are captured at the edge that issues grant, so they
// may change freely afterwards. The op is applied at the next edge, where the
// one-cycle ack pulse also starts. grant, ack and busy clear together at the
// edge that ends the DONE cycle. A req still high at that point competes
// again in IDLE, under round-robin priority.
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] j_in,
    input  logic [NREQ*WIDTH-1:0] k_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      q1
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // state is the observable FSM state for checkers bound to this block.
    state_t          state;
    state_t          state_nx;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    win_lat;
    logic [IW-1:0]    cand;
    logic             found;
    logic [WIDTH-1:0] j_win;
    logic [WIDTH-1:0] k_win;
    logic [WIDTH-1:0] j_lat;
    logic [WIDTH-1:0] k_lat;

    // Scan lanes starting at rr_ptr and take the first request found.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = rr_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Select the J/K vectors of the lane that would win this cycle.
    always_comb begin
        j_win = '0;
        k_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                j_win = WIDTH'(j_in >> (i * WIDTH));
                k_win = WIDTH'(k_in >> (i * WIDTH));
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. A transaction always takes exactly three cycles.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = APPLY;
            APPLY:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: grant and latch in IDLE, update the bank in APPLY, clear in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            q       <= '0;
            rr_ptr  <= '0;
            win_lat <= '0;
            j_lat   <= '0;
            k_lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= NREQ'(1) << win_idx;
                        win_lat <= win_idx;
                        j_lat   <= j_win;
                        k_lat   <= k_win;
                        busy    <= 1'b1;
                    end
                end
                APPLY: begin
                    // Per bit: JK=00 hold, 01 clear, 10 set, 11 toggle.
                    q      <= (j_lat & ~q) | (~k_lat & q);
                    ack    <= grant;
                    rr_ptr <= (win_lat == IW'(NREQ - 1)) ? '0 : win_lat + 1'b1;
                end
                DONE: begin
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Complementary output. It equals ~q in every cycle, including reset.
    assign q1 = ~q;

endmodule
